// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scanner: SHOW/BLANK time multiplexing with a
// double-buffered display value that commits only at frame boundaries.
module seg_scan_mux #(
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  nibble,
  output logic        dp,
  output logic [1:0]  select,
  output logic        blank,
  output logic        frame_done
);

  localparam int unsigned CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic {ST_BLANK, ST_SHOW} phase_t;

  phase_t        phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    sel, sel_n;
  logic [3:0]    nib, nib_n;
  logic          dp_q, dp_n;
  logic          blank_q, blank_n;
  logic          fd_q, fd_n;
  logic [15:0]   act_val, act_val_n, sh_val, sh_val_n;
  logic [3:0]    act_dp, act_dp_n, sh_dp, sh_dp_n;
  logic [3:0]    act_en, act_en_n, sh_en, sh_en_n;
  logic          pending, pending_n;
  logic          last, wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= ST_BLANK;
      cnt     <= CW'(BLANK_CYCLES);
      sel     <= '0;
      nib     <= '0;
      dp_q    <= 1'b0;
      blank_q <= 1'b1;
      fd_q    <= 1'b0;
      act_val <= '0;
      act_dp  <= '0;
      act_en  <= '0;
      sh_val  <= '0;
      sh_dp   <= '0;
      sh_en   <= '0;
      pending <= 1'b0;
    end else begin
      phase   <= phase_n;
      cnt     <= cnt_n;
      sel     <= sel_n;
      nib     <= nib_n;
      dp_q    <= dp_n;
      blank_q <= blank_n;
      fd_q    <= fd_n;
      act_val <= act_val_n;
      act_dp  <= act_dp_n;
      act_en  <= act_en_n;
      sh_val  <= sh_val_n;
      sh_dp   <= sh_dp_n;
      sh_en   <= sh_en_n;
      pending <= pending_n;
    end
  end

  always_comb begin
    phase_n   = phase;
    cnt_n     = cnt - CW'(1);
    sel_n     = sel;
    nib_n     = nib;
    dp_n      = dp_q;
    blank_n   = blank_q;
    act_val_n = act_val;
    act_dp_n  = act_dp;
    act_en_n  = act_en;
    sh_val_n  = sh_val;
    sh_dp_n   = sh_dp;
    sh_en_n   = sh_en;
    pending_n = pending;

    last = (cnt == CW'(1));
    wrap = (phase == ST_SHOW) && last && (sel == 2'd3);

    // A load coinciding with the boundary bypasses the shadow wait.
    if (wrap) begin
      if (load) begin
        act_val_n = value;
        act_dp_n  = dp_in;
        act_en_n  = digit_en;
        pending_n = 1'b0;
      end else if (pending) begin
        act_val_n = sh_val;
        act_dp_n  = sh_dp;
        act_en_n  = sh_en;
        pending_n = 1'b0;
      end
    end
    if (load) begin
      sh_val_n = value;
      sh_dp_n  = dp_in;
      sh_en_n  = digit_en;
      if (!wrap) pending_n = 1'b1;
    end

    case (phase)
      ST_BLANK: begin
        if (last) begin
          phase_n = ST_SHOW;
          cnt_n   = CW'(PRESCALE);
          blank_n = ~act_en[sel];
        end
      end
      default: begin
        if (last) begin
          phase_n = ST_BLANK;
          cnt_n   = CW'(BLANK_CYCLES);
          sel_n   = sel + 2'd1;
          blank_n = 1'b1;
          nib_n   = act_val_n[{sel_n, 2'b00} +: 4];
          dp_n    = act_dp_n[sel_n];
        end
      end
    endcase

    // frame_done is registered one cycle early so it is high during the
    // final cycle of the frame, i.e. the cycle whose closing edge is the boundary.
    fd_n = (phase_n == ST_SHOW) && (cnt_n == CW'(1)) && (sel_n == 2'd3);
  end

  assign nibble     = nib;
  assign dp         = dp_q;
  assign select     = sel;
  assign blank      = blank_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized bench for seg_scan_mux; expectations come from a slot/time
// model of the display (PRESCALE=4, BLANK_CYCLES=2, 24-cycle frame).
module tb_seg_scan_mux;

  localparam int P = 4;
  localparam int B = 2;
  localparam int SLOT = P + B;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in, digit_en;
  logic [3:0]  nibble;
  logic        dp, blank, frame_done;
  logic [1:0]  select;

  int total = 0;
  int bad = 0;

  int          t;
  logic [15:0] m_val, m_sh_val;
  logic [3:0]  m_dp, m_sh_dp, m_en, m_sh_en;
  bit          m_pend;

  seg_scan_mux #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .nibble(nibble), .dp(dp), .select(select),
    .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_val = '0; m_dp = '0; m_en = '0;
    m_sh_val = '0; m_sh_dp = '0; m_sh_en = '0;
    m_pend = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_sel", 16'(select), 16'd0);
    check("rst_nib", 16'(nibble), 16'd0);
    check("rst_dp", 16'(dp), 16'd0);
    check("rst_blank", 16'(blank), 16'd1);
    check("rst_fd", 16'(frame_done), 16'd0);
  endtask

  // Entered at a negedge, leaves at the next negedge.
  task automatic cycle(input bit ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    int slot;
    bit show;
    bool_dummy: begin end
    slot = (t / SLOT) % 4;
    show = (t % SLOT) >= B;
    check("select", 16'(select), 16'(slot));
    check("nibble", 16'(nibble), 16'((m_val >> (4 * slot)) & 16'hF));
    check("dp", 16'(dp), 16'(m_dp[slot]));
    check("blank", 16'(blank), 16'(!(show && m_en[slot])));
    check("frame_done", 16'(frame_done), 16'((t % FRAME) == FRAME - 1));
    load = ld; value = v; dp_in = d; digit_en = e;
    @(posedge clk);
    if (ld) begin
      m_sh_val = v; m_sh_dp = d; m_sh_en = e;
      if ((t % FRAME) == FRAME - 1) begin
        m_val = v; m_dp = d; m_en = e; m_pend = 0;
      end else begin
        m_pend = 1;
      end
    end else if ((t % FRAME) == FRAME - 1 && m_pend) begin
      m_val = m_sh_val; m_dp = m_sh_dp; m_en = m_sh_en; m_pend = 0;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, $urandom, $urandom, $urandom);
  endtask

  task automatic run_until(input int m);
    for (int i = 0; i < FRAME && (t % FRAME) != m; i++) cycle(0, '0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; digit_en = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    model_reset();

    idle(48);

    idle(5);
    cycle(1, 16'hA5C3, 4'b0100, 4'hF);
    idle(60);

    run_until(3);
    cycle(1, 16'h1111, 4'b0001, 4'hF);
    idle(6);
    cycle(1, 16'h2222, 4'b0010, 4'hF);
    idle(30);

    run_until(FRAME - 1);
    cycle(1, 16'hBEEF, 4'b0000, 4'hF);
    idle(30);

    cycle(1, 16'h1234, 4'b1001, 4'b1010);
    idle(50);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(7) == 0, 16'($urandom), 4'($urandom), 4'($urandom));

    cycle(1, 16'h9C7E, 4'b0100, 4'hF);
    run_until(0);
    run_until(15);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexing scanner for the four-digit seven-segment display on the board. Holds a 16-bit hex display value plus per-digit decimal points, cycles through the four digits at a programmable refresh rate, and presents one nibble, its decimal point and the 2-bit digit select per slot to the downstream segment and anode decoders. Also inserts a blanking interval between digits to suppress ghosting. New values are double-buffered and take effect only at frame boundaries, so the display never tears.

## Interface
- PRESCALE, 100000: clock cycles each digit is lit (SHOW phase); legal range ≥1.
- BLANK_CYCLES, 16: clock cycles all anodes are off between digits (BLANK phase); legal range ≥1.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  single-cycle strobe; captures value, dp_in, digit_en into the shadow buffer.
- value  in  16  four hex digits; digit k = value[4k+3:4k], digit 0 rightmost.
- dp_in  in  4  decimal point per digit, bit k = digit k.
- digit_en  in  4  per-digit enable; a disabled digit stays blanked for its slot.
- nibble  out  4  hex value of the current digit, to the segment decoder.
- dp  out  1  decimal point of the current digit.
- select  out  2  current digit index, to the anode decoder.
- blank  out  1  high = downstream forces all anodes off.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Two phases, SHOW and BLANK, with a down-counter sized for max(PRESCALE, BLANK_CYCLES).
- SHOW: blank = ~active_en[select]; lasts PRESCALE cycles, then BLANK.
- SHOW→BLANK edge: blank←1; select←select+1 (3 wraps to 0); nibble, dp reloaded from the active buffer at the new select.
- BLANK: blank=1 for BLANK_CYCLES cycles, then SHOW on the same select.
- Frame boundary = the SHOW→BLANK edge where select wraps 3→0. At that edge: frame_done=1 for exactly that cycle; if pending, active buffer ← shadow and pending←0; nibble/dp use the newly committed data.
- load: shadow ← {value, dp_in, digit_en}, pending←1. Repeated loads before commit overwrite the shadow (last wins).
- load on the frame-boundary edge: the loaded data is committed directly at that edge; pending ends 0.
- The active buffer changes only at frame boundaries; mid-frame loads never alter the current frame.
- Disabled digits keep their slot (no skipping), giving constant per-digit duty.
- No arithmetic beyond the counter decrement and 2-bit select increment (modulo 4).

## Timing
- Reset (async assert, any state): select=0, nibble=0, dp=0, blank=1, frame_done=0, phase=BLANK, counter loaded with BLANK_CYCLES, active and shadow buffers=0 (all digits disabled), pending=0.
- After rst_n deasserts: BLANK_CYCLES cycles blank=1, then SHOW for digit 0 (stays blanked until a commit enables digits).
- Digit period = PRESCALE + BLANK_CYCLES cycles; frame = 4×(PRESCALE + BLANK_CYCLES).
- All outputs registered; select, nibble, dp, blank change on the same edge.
- Load-to-display latency: 1 to one full frame, always landing on a frame boundary.
- Reset mid-frame: all shadow and pending data discarded; resumes from the reset state.

## Test plan
- PRESCALE=4, BLANK_CYCLES=2, release reset, no load -> blank=1 continuously; select sequence 0,1,2,3 each 6 cycles; frame_done pulses every 24 cycles on the 3→0 edge.
- load value=16'hA5C3, dp_in=4'b0100, digit_en=4'hF mid-frame -> current frame stays blanked; after next frame_done, slots show nibble 3,C,5,A with dp=1 only at select=2; blank=0 for 4 cycles per slot.
- Two loads (16'h1111 then 16'h2222) in one frame -> only 2222 ever displayed.
- load 16'hBEEF on the exact frame_done cycle -> digit 0 shows F in that same frame; no extra frame delay.
- digit_en=4'b1010 -> blank stays 1 during SHOW of select 0 and 2; slot timing unchanged (6 cycles each).
- Assert rst_n=0 during SHOW of digit 2 with data active -> outputs immediately select=0, nibble=0, dp=0, blank=1; after release, display blank until a new load commits.
